// File: rtl/lib_intc_pkg.sv
// Shared types and constants for the multi-source interrupt controller.
package lib_intc;

    localparam int unsigned INTC_DATA_W   = 32;
    localparam int unsigned INTC_ID_MAX_W = 4;

    localparam logic CFG_MASK  = 1'b0;
    localparam logic CFG_VBASE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } INTC_STATE;

    // Request bundle merged by the decode stage into its special-register set
    typedef struct packed {
        logic                     irr;
        logic [INTC_DATA_W-1:0]   intr_vec;
        logic [INTC_ID_MAX_W-1:0] active_id;
    } INTC_OUT;

    // Handler address: one 4-byte slot per source above the vector base
    function automatic logic [INTC_DATA_W-1:0] intc_vec(
        input logic [INTC_DATA_W-1:0]   base,
        input logic [INTC_ID_MAX_W-1:0] id
    );
        return base + (INTC_DATA_W'(id) << 2);
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder; index 0 has highest priority.
module prio_enc #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [W-1:0] id_o
);

    always_comb begin
        valid_o = |req_i;
        id_o    = '0;
        // Scan downwards so the lowest set index is written last
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o = W'(i);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// N_SRC-source fixed-priority interrupt controller with ack/eoi handshake.
// Define INTC_EDGE_DETECT_EN for rising-edge sources; default is level mode.
module intr_ctrl
    import lib_intc::*;
#(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SRC-1:0]       src,
    input  logic                   cfg_we,
    input  logic                   cfg_addr,
    input  logic [INTC_DATA_W-1:0] cfg_wdata,
    input  logic                   ack,
    input  logic                   eoi,
    output logic                   irr,
    output logic [INTC_DATA_W-1:0] intr_vec,
    output logic [ID_W-1:0]        active_id,
    output logic [N_SRC-1:0]       pending
);

    INTC_STATE              state_q;
    logic [N_SRC-1:0]       mask_q;
    logic [INTC_DATA_W-1:0] vbase_q;
    logic [N_SRC-1:0]       pend_q;
    logic [N_SRC-1:0]       pend_d;
    logic                   irr_q;
    logic [INTC_DATA_W-1:0] vec_q;
    logic [ID_W-1:0]        id_q;

    logic [N_SRC-1:0]       evt_c;
    logic [N_SRC-1:0]       clr_c;
    logic [N_SRC-1:0]       cand_c;
    logic                   win_vld_c;
    logic [ID_W-1:0]        win_id_c;

`ifdef INTC_EDGE_DETECT_EN
    logic [N_SRC-1:0] src_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q <= '0;
        end else begin
            src_q <= src;
        end
    end

    assign evt_c = src & ~src_q;
`else
    assign evt_c = src;
`endif

    // A new event on the bit being acknowledged wins over the clear
    assign clr_c  = (state_q == REQ && ack) ? (N_SRC'(1) << id_q) : '0;
    assign pend_d = (pend_q & ~clr_c) | evt_c;
    assign cand_c = pend_q & mask_q;

    prio_enc #(
        .N (N_SRC),
        .W (ID_W)
    ) u_prio_enc (
        .req_i   (cand_c),
        .valid_o (win_vld_c),
        .id_o    (win_id_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q  <= '0;
            vbase_q <= '0;
        end else if (cfg_we) begin
            if (cfg_addr == CFG_VBASE) begin
                vbase_q <= cfg_wdata;
            end else begin
                mask_q <= cfg_wdata[N_SRC-1:0];
            end
        end
    end

    // Request handshake; id and vector stay frozen from latch until the next latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            irr_q   <= 1'b0;
            vec_q   <= '0;
            id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld_c) begin
                        id_q    <= win_id_c;
                        vec_q   <= intc_vec(vbase_q, INTC_ID_MAX_W'(win_id_c));
                        irr_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (ack) begin
                        irr_q   <= 1'b0;
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (eoi) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    irr_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign irr       = irr_q;
    assign intr_vec  = vec_q;
    assign active_id = id_q;
    assign pending   = pend_q;

endmodule
